pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter stage that sits directly downstream of the branch-target adder in the MIPS single-cycle datapath.
- Holds the architectural PC and computes PC+4.
- Selects the next PC from the sequential path, the branch target, the jump target or the register target.
- Drives a request/ready fetch handshake to instruction memory; a misaligned redirect traps the fetch.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (must be word-aligned)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard/hold request; suppresses fetch while high
branch_taken  in  1  branch condition true for the current instruction
pc_branch  in  32  branch target from the branch-target adder
jump  in  1  J/JAL in the current instruction
jump_index  in  26  instr[25:0] of J/JAL
jr  in  1  JR in the current instruction
jr_target  in  32  register operand for JR
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, always equal to pc
imem_ready  in  1  instruction memory accepts or returns this cycle
pc  out  32  current PC
pc_plus4  out  32  pc + 4, combinational
instr_valid  out  1  one-cycle pulse: instruction at pc fetched this cycle
misalign_err  out  1  sticky trap flag
err_addr  out  32  offending target address

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_VECTOR, state = BOOT.
  - imem_req = 0, instr_valid = 0, misalign_err = 0, err_addr = 0.
  - Reset asserted mid-handshake aborts it immediately; no state is retained.
- States:
  - BOOT: one cycle after reset release, imem_req = 0; always goes to FETCH.
  - FETCH: imem_req = ~stall.
  - TRAP: imem_req = 0, pc frozen; TRAP is left only by reset.
- Acceptance: accept = state==FETCH & imem_req & imem_ready.
  - instr_valid = accept, combinational and same cycle.
  - Redirect inputs are sampled only on accept; they are ignored otherwise.
- Next-PC priority, highest first:
  - jr → jr_target.
  - jump → {pc_plus4[31:28], jump_index, 2'b00}.
  - branch_taken → pc_branch.
  - otherwise pc_plus4.
- On accept:
  - If next_pc[1:0] != 0: pc holds, err_addr = next_pc, misalign_err = 1, go to TRAP.
  - Else pc <= next_pc and stay in FETCH.
- imem_ready low in FETCH: pc holds, imem_req stays high, no pulse. Latency is one cycle per instruction when ready is tied high.
- Stall high: imem_req = 0, so no accept can occur; pc holds. Stall and ready both high still means no accept.
- Arithmetic is modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no error flag.
- Simultaneous jr, jump and branch_taken resolve by the priority above; the lower-priority targets are discarded.
- imem_addr == pc in every state.

Test Plan:
- Reset release, imem_ready = 1, no redirects:
  - BOOT cycle shows imem_req = 0.
  - Following cycles give pc 0x0, 0x4, 0x8, 0xC, with instr_valid high each cycle.
- pc = 0x1000, branch_taken = 1, pc_branch = 0x1014 on accept → next pc = 0x1014. Repeat with pc_branch = 0x1000 (backward offset) → next pc = 0x1000.
- Target forms:
  - pc = 0x0040_0008, jump = 1, jump_index = 0x000_0100 → next pc = 0x0000_0400.
  - Same cycle with jr = 1, jr_target = 0x2000 → next pc = 0x2000 (jr wins).
- jr_target = 0x2002 on accept:
  - misalign_err = 1, err_addr = 0x2002, pc holds, imem_req = 0 thereafter.
  - Pulsing rst_n returns pc to RESET_VECTOR and clears misalign_err.
- Stall and ready sequencing:
  - stall = 1 for 3 cycles with ready = 1 → no instr_valid, pc constant; release → advance resumes.
  - ready low for 2 cycles → imem_req held high and pc held.
- Edge cases:
  - pc = 0xFFFF_FFFC, sequential accept → pc = 0x0, no error.
  - rst_n dropped mid-cycle while imem_req = 1 → outputs reset asynchronously before the next clock edge.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program-counter stage of the MIPS single-cycle datapath. Holds the
//   architectural PC, forms PC+4, picks the next PC (JR > J/JAL > branch >
//   sequential) and runs a request/ready fetch handshake to instruction
//   memory. A redirect to a non-word-aligned address traps the fetch until
//   reset.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   stall         in   hold request; suppresses the fetch request
//   branch_taken  in   branch condition for the current instruction
//   pc_branch     in   branch target from the branch-target adder
//   jump          in   J/JAL in the current instruction
//   jump_index    in   instr[25:0] of J/JAL
//   jr            in   JR in the current instruction
//   jr_target     in   register operand for JR
//   imem_req      out  fetch request
//   imem_addr     out  fetch address (always equals pc)
//   imem_ready    in   instruction memory accepts/returns this cycle
//   pc            out  current PC
//   pc_plus4      out  pc + 4 (combinational, wraps modulo 2^32)
//   instr_valid   out  one-cycle pulse: instruction at pc fetched this cycle
//   misalign_err  out  sticky trap flag
//   err_addr      out  offending target address
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] pc_branch,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic        r_misalign_err;
  logic [31:0] r_err_addr;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_req;
  logic        w_accept;
  logic        w_misaligned;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Redirect priority: JR beats J/JAL beats a taken branch.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jr) begin
      w_next_pc = jr_target;
    end else if (jump) begin
      w_next_pc = {w_pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      w_next_pc = pc_branch;
    end
  end

  assign w_misaligned = (w_next_pc[1:0] != 2'b00);

  // Next-state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      BOOT: begin
        w_next_state = FETCH;
      end
      FETCH: begin
        w_req    = ~stall;
        w_accept = w_req & imem_ready;
        if (w_accept && w_misaligned) begin
          w_next_state = TRAP;
        end
      end
      TRAP: begin
        w_next_state = TRAP;
      end
      default: begin
        w_next_state = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // PC and trap registers; redirect inputs only matter on an accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc           <= RESET_VECTOR;
      r_misalign_err <= 1'b0;
      r_err_addr     <= 32'h0000_0000;
    end else if (w_accept) begin
      if (w_misaligned) begin
        r_misalign_err <= 1'b1;
        r_err_addr     <= w_next_pc;
      end else begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign instr_valid  = w_accept;
  assign misalign_err = r_misalign_err;
  assign err_addr     = r_err_addr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] pc_branch;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign_err;
  logic [31:0] err_addr;

  int n_vec;
  int n_err;

  pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .pc_branch    (pc_branch),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err),
    .err_addr     (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Full observable state check; imem_addr must track pc everywhere.
  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_req,
                           input logic e_vld, input logic e_err, input logic [31:0] e_eaddr);
    check_val({tag, ".pc"},       pc,                   e_pc);
    check_val({tag, ".addr"},     imem_addr,            e_pc);
    check_val({tag, ".req"},      {31'd0, imem_req},    {31'd0, e_req});
    check_val({tag, ".vld"},      {31'd0, instr_valid}, {31'd0, e_vld});
    check_val({tag, ".err"},      {31'd0, misalign_err},{31'd0, e_err});
    check_val({tag, ".err_addr"}, err_addr,             e_eaddr);
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_redirects();
    jr = 1'b0; jr_target = 32'd0;
    jump = 1'b0; jump_index = 26'd0;
    branch_taken = 1'b0; pc_branch = 32'd0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    imem_ready = 1'b1;
    clr_redirects();

    @(negedge clk);
    check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // BOOT cycle after release: no request
    rst_n = 1'b1;
    #1;
    check_all("boot", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_all("seq0", 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_val("seq0.plus4", pc_plus4, 32'h4);
    step();
    check_all("seq4", 32'h4, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check_all("seq8", 32'h8, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check_all("seqC", 32'hC, 1'b1, 1'b1, 1'b0, 32'h0);

    // Branch forward and backward from 0x1000
    jr = 1'b1; jr_target = 32'h0000_1000;
    step();
    clr_redirects();
    check_val("jr1000", pc, 32'h0000_1000);
    branch_taken = 1'b1; pc_branch = 32'h0000_1014;
    step();
    check_val("br_fwd", pc, 32'h0000_1014);
    pc_branch = 32'h0000_1000;
    step();
    check_val("br_back", pc, 32'h0000_1000);
    clr_redirects();

    // Jump target formation
    jr = 1'b1; jr_target = 32'h0040_0008;
    step();
    clr_redirects();
    check_val("jr400008", pc, 32'h0040_0008);
    check_val("plus4_40000C", pc_plus4, 32'h0040_000C);
    jump = 1'b1; jump_index = 26'h000_0100;
    step();
    check_val("jump", pc, 32'h0000_0400);

    // All three redirects together: jr wins
    jr = 1'b1; jr_target = 32'h0000_2000;
    jump = 1'b1; jump_index = 26'h000_0100;
    branch_taken = 1'b1; pc_branch = 32'h0000_3000;
    step();
    clr_redirects();
    check_val("prio_jr", pc, 32'h0000_2000);

    // Jump beats branch when jr is absent
    jump = 1'b1; jump_index = 26'h000_0900;
    branch_taken = 1'b1; pc_branch = 32'h0000_3000;
    step();
    clr_redirects();
    check_val("prio_jump", pc, 32'h0000_2400);
    jr = 1'b1; jr_target = 32'h0000_2000;
    step();
    clr_redirects();

    // Stall three cycles with ready high; redirects ignored while stalled
    stall = 1'b1;
    branch_taken = 1'b1; pc_branch = 32'h0000_5000;
    #1;
    check_all("stall0", 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("stall", 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    clr_redirects();
    stall = 1'b0;
    #1;
    check_val("unstall.vld", {31'd0, instr_valid}, 32'd1);
    step();
    check_val("unstall.pc", pc, 32'h0000_2004);

    // Ready low two cycles
    imem_ready = 1'b0;
    #1;
    check_all("rdy_lo0", 32'h2004, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_all("rdy_lo", 32'h2004, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    imem_ready = 1'b1;
    step();
    check_val("rdy_hi.pc", pc, 32'h0000_2008);

    // Wrap from 0xFFFF_FFFC
    jr = 1'b1; jr_target = 32'hFFFF_FFFC;
    step();
    clr_redirects();
    check_val("wrap.pc", pc, 32'hFFFF_FFFC);
    check_val("wrap.plus4", pc_plus4, 32'h0000_0000);
    step();
    check_all("wrapped", 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned JR traps
    jr = 1'b1; jr_target = 32'h0000_2002;
    step();
    clr_redirects();
    check_all("trap", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_2002);
    jr = 1'b1; jr_target = 32'h0000_3000;
    step();
    clr_redirects();
    check_all("trap_hold", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_2002);

    // Reset pulse clears the trap
    rst_n = 1'b0;
    #1;
    check_all("trap_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    step();
    check_all("post_rst", 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check_all("post_rst4", 32'h4, 1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset mid-handshake, before the next rising edge
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("async_boot", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
